// File: rtl/rate_scheduler.sv
// Programmable-rate tick scheduler: IDLE/RUN/STOPPING sequencer emitting a period-end tick
// and a 50% square wave. Optional single-step tick in IDLE when STEP_MODE_EN is defined.
//
// state    | meaning
// IDLE     | halted, cnt held at 0, outputs low
// RUN      | counting periods at rate_cur, new sel taken at each wrap
// STOPPING | finishing the current period, then back to IDLE
module rate_scheduler #(
  parameter int CLK_HZ = 50000000,
  parameter int RATE0  = 1,
  parameter int RATE1  = 2,
  parameter int RATE2  = 6,
  parameter int RATE3  = 12,
  parameter int CW     = 26
) (
  input  logic       clock50,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] sel,
  input  logic       step,
  output logic       tick,
  output logic       clk_out,
  output logic       running,
  output logic [1:0] rate_cur
);

  localparam int H0I = CLK_HZ / (2 * RATE0);
  localparam int H1I = CLK_HZ / (2 * RATE1);
  localparam int H2I = CLK_HZ / (2 * RATE2);
  localparam int H3I = CLK_HZ / (2 * RATE3);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] half, last;
  logic [1:0]    rate_nxt;
  logic          period_end;
  logic          step_req;
  logic          step_pulse;

`ifdef STEP_MODE_EN
  assign step_req = (state == IDLE) && step;
`else
  logic step_unused;
  assign step_unused = step;
  assign step_req    = 1'b0;
`endif

  always_comb begin
    half = CW'(H0I);
    last = CW'(2 * H0I - 1);
    case (rate_cur)
      2'd1: begin half = CW'(H1I); last = CW'(2 * H1I - 1); end
      2'd2: begin half = CW'(H2I); last = CW'(2 * H2I - 1); end
      2'd3: begin half = CW'(H3I); last = CW'(2 * H3I - 1); end
      default: ;
    endcase
  end

  assign period_end = (state != IDLE) && (cnt == last);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rate_nxt  = rate_cur;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          rate_nxt  = sel;
        end
      end
      RUN: begin
        if (period_end) begin
          cnt_nxt  = '0;
          rate_nxt = sel;
          // a stop landing on the final cycle of a period halts right here
          if (stop) state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
          if (stop) state_nxt = STOPPING;
        end
      end
      STOPPING: begin
        if (period_end) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock50) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      rate_cur   <= 2'd0;
      step_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rate_cur   <= rate_nxt;
      step_pulse <= step_req;
    end
  end

  assign running = (state != IDLE);
  assign clk_out = running && (cnt < half);
  assign tick    = period_end || step_pulse;

endmodule
